// File: rtl/alu_rr_sched.sv
// alu_rr_sched: two-requester scheduler sharing one registered 4-bit ALU.
// Requests are arbitrated in IDLE (round-robin, or fixed priority to requester 0),
// the operands are held while the ALU pipeline computes, and the tagged 8-bit
// result is offered on a valid/ready response channel.
// Optional feature macro: ALU_RR_SCHED_STATS_EN adds saturating grant/stall counters.

// Registered 4-bit ALU: input registers, then an output register (two-cycle latency).
module alu_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [1:0] op,
   output logic [7:0] y
);
   logic [3:0] a_r;
   logic [3:0] b_r;
   logic [1:0] op_r;
   logic [7:0] res_s;

   // Capture operands every cycle; the scheduler keeps them stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r  <= 4'd0;
         b_r  <= 4'd0;
         op_r <= 2'd0;
      end else begin
         a_r  <= a;
         b_r  <= b;
         op_r <= op;
      end
   end

   // Combinational arithmetic on the captured operands.
   always_comb begin
      res_s = 8'd0;
      case (op_r)
         2'd0:    res_s = {4'd0, a_r} + {4'd0, b_r};
         2'd1:    res_s = {4'd0, a_r} * {4'd0, b_r};
         2'd2:    res_s = {4'd0, a_r} - {4'd0, b_r};
         2'd3:    res_s = {4'd0, a_r & b_r};
         default: res_s = 8'd0;
      endcase
   end

   // Register the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y <= 8'd0;
      end else begin
         y <= res_s;
      end
   end
endmodule

module alu_rr_sched #(
   parameter int FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   output logic [1:0] req_ready,
   input  logic [3:0] req_a0,
   input  logic [3:0] req_b0,
   input  logic [1:0] req_op0,
   input  logic [3:0] req_a1,
   input  logic [3:0] req_b1,
   input  logic [1:0] req_op1,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic       resp_id,
   output logic [7:0] resp_data,
`ifdef ALU_RR_SCHED_STATS_EN
   output logic [7:0] grant_cnt0,
   output logic [7:0] grant_cnt1,
   output logic [7:0] stall_cnt,
`endif
   output logic       busy
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [1:0] grant_s;
   logic       accept_s;
   logic       last_grant_r;
   logic       id_r;
   logic [3:0] a_r;
   logic [3:0] b_r;
   logic [1:0] op_r;
   logic [7:0] alu_y_s;

   // Arbitration: only meaningful in IDLE; last_grant_r resets to 1 so requester 0 wins first.
   always_comb begin
      grant_s = 2'b00;
      if (state_r == IDLE) begin
         case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11: begin
               if (FIXED_PRIO != 0) begin
                  grant_s = 2'b01;
               end else begin
                  grant_s = last_grant_r ? 2'b01 : 2'b10;
               end
            end
            default: grant_s = 2'b00;
         endcase
      end else begin
         grant_s = 2'b00;
      end
   end

   assign req_ready = grant_s;
   assign accept_s  = |(req_valid & grant_s);

   // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP sequence.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE:   state_nxt_s = WAIT;
         WAIT:    state_nxt_s = RESP;
         RESP: begin
            if (resp_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Latch the granted requester's operation; holding regs feed the ALU until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r          <= 4'd0;
         b_r          <= 4'd0;
         op_r         <= 2'd0;
         id_r         <= 1'b0;
         last_grant_r <= 1'b1;
      end else if (accept_s) begin
         a_r          <= grant_s[1] ? req_a1  : req_a0;
         b_r          <= grant_s[1] ? req_b1  : req_b0;
         op_r         <= grant_s[1] ? req_op1 : req_op0;
         id_r         <= grant_s[1];
         last_grant_r <= grant_s[1];
      end else begin
         a_r          <= a_r;
         b_r          <= b_r;
         op_r         <= op_r;
         id_r         <= id_r;
         last_grant_r <= last_grant_r;
      end
   end

   alu_seq u_alu (
      .clk (clk),
      .rst (~rst_n),
      .a   (a_r),
      .b   (b_r),
      .op  (op_r),
      .y   (alu_y_s)
   );

   assign resp_valid = (state_r == RESP);
   assign resp_data  = alu_y_s;
   assign resp_id    = id_r;
   assign busy       = (state_r != IDLE);

`ifdef ALU_RR_SCHED_STATS_EN
   // Increment by one, holding at all-ones.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v == 8'hFF) begin
         sat_inc = v;
      end else begin
         sat_inc = v + 8'd1;
      end
   endfunction

   logic [7:0] g0_r;
   logic [7:0] g1_r;
   logic [7:0] stall_r;

   // Saturating per-requester grant counters and response stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g0_r    <= 8'd0;
         g1_r    <= 8'd0;
         stall_r <= 8'd0;
      end else begin
         if (accept_s && grant_s[0]) g0_r <= sat_inc(g0_r);
         else                        g0_r <= g0_r;
         if (accept_s && grant_s[1]) g1_r <= sat_inc(g1_r);
         else                        g1_r <= g1_r;
         if ((state_r == RESP) && !resp_ready) stall_r <= sat_inc(stall_r);
         else                                  stall_r <= stall_r;
      end
   end

   assign grant_cnt0 = g0_r;
   assign grant_cnt1 = g1_r;
   assign stall_cnt  = stall_r;
`endif
endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a response scoreboard; a second instance
// with FIXED_PRIO=1 checks fixed-priority arbitration.
module tb_alu_rr_sched;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_ready;
   logic [3:0] req_a0 = 4'd0, req_b0 = 4'd0, req_a1 = 4'd0, req_b1 = 4'd0;
   logic [1:0] req_op0 = 2'd0, req_op1 = 2'd0;
   logic       resp_valid, resp_id, busy;
   logic       resp_ready = 1'b1;
   logic [7:0] resp_data;

   logic [1:0] req_valid_fp = 2'b00;
   logic [1:0] req_ready_fp;
   logic       resp_valid_fp, resp_id_fp, busy_fp;
   logic       resp_ready_fp = 1'b1;
   logic [7:0] resp_data_fp;

`ifdef ALU_RR_SCHED_STATS_EN
   logic [7:0] grant_cnt0, grant_cnt1, stall_cnt;
   logic [7:0] grant_cnt0_fp, grant_cnt1_fp, stall_cnt_fp;
`endif

   int         n_vec = 0;
   int         n_fail = 0;
   logic       exp_last = 1'b1;
   int         exp_g0 = 0, exp_g1 = 0, exp_stall = 0;
   logic       sb_id[$];
   logic [7:0] sb_data[$];

   always #5 clk = ~clk;

   alu_rr_sched #(.FIXED_PRIO(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data),
`ifdef ALU_RR_SCHED_STATS_EN
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt),
`endif
      .busy(busy));

   alu_rr_sched #(.FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_fp), .req_ready(req_ready_fp),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
      .resp_valid(resp_valid_fp), .resp_ready(resp_ready_fp), .resp_id(resp_id_fp),
      .resp_data(resp_data_fp),
`ifdef ALU_RR_SCHED_STATS_EN
      .grant_cnt0(grant_cnt0_fp), .grant_cnt1(grant_cnt1_fp), .stall_cnt(stall_cnt_fp),
`endif
      .busy(busy_fp));

   // Reference arithmetic, written from the opcode table.
   function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int r;
      case (op)
         2'd0:    r = int'(a) + int'(b);
         2'd1:    r = int'(a) * int'(b);
         2'd2:    r = (int'(a) - int'(b) + 256) % 256;
         default: r = int'(a & b);
      endcase
      return 8'(r);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      req_valid_fp = 2'b00;
      resp_ready = 1'b1;
      resp_ready_fp = 1'b1;
      sb_id.delete();
      sb_data.delete();
      exp_last = 1'b1;
      exp_g0 = 0; exp_g1 = 0; exp_stall = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One operation on the round-robin instance, starting at a negedge in IDLE.
   task automatic run_op(input string tag, input logic [1:0] vmask, input int stall);
      logic [1:0] eg;
      logic       eid;
      logic [7:0] ed;
      req_valid = vmask;
      #1;
      if (vmask == 2'b11) eg = exp_last ? 2'b01 : 2'b10;
      else                eg = vmask;
      check({tag, ":grant"}, {6'd0, req_ready}, {6'd0, eg});
      eid = eg[1];
      ed  = eid ? model(req_a1, req_b1, req_op1) : model(req_a0, req_b0, req_op0);
      sb_id.push_back(eid);
      sb_data.push_back(ed);
      exp_last = eid;
      if (eid) exp_g1 = (exp_g1 < 255) ? exp_g1 + 1 : 255;
      else     exp_g0 = (exp_g0 < 255) ? exp_g0 + 1 : 255;
      // Other requester stays valid while busy: must be ignored.
      @(negedge clk);
      req_valid = vmask & ~eg;
      #1;
      check({tag, ":issue_busy"}, {7'd0, busy}, 8'd1);
      check({tag, ":issue_ready"}, {6'd0, req_ready}, 8'd0);
      @(negedge clk);
      #1;
      check({tag, ":wait_valid"}, {7'd0, resp_valid}, 8'd0);
      @(negedge clk);
      resp_ready = (stall == 0);
      #1;
      check({tag, ":resp_valid"}, {7'd0, resp_valid}, 8'd1);
      for (int i = 0; i < stall; i++) begin
         check({tag, ":stall_valid"}, {7'd0, resp_valid}, 8'd1);
         check({tag, ":stall_data"}, resp_data, ed);
         check({tag, ":stall_ready"}, {6'd0, req_ready}, 8'd0);
         exp_stall = (exp_stall < 255) ? exp_stall + 1 : 255;
         @(negedge clk);
         resp_ready = (i == stall - 1);
         #1;
      end
      if (sb_data.size() == 0) begin
         check({tag, ":sb_empty"}, 8'd1, 8'd0);
      end else begin
         check({tag, ":resp_id"}, {7'd0, resp_id}, {7'd0, sb_id.pop_front()});
         check({tag, ":resp_data"}, resp_data, sb_data.pop_front());
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check({tag, ":idle_busy"}, {7'd0, busy}, 8'd0);
      check({tag, ":idle_valid"}, {7'd0, resp_valid}, 8'd0);
   endtask

   initial begin
      @(negedge clk);
      #1;
      check("rst:resp_valid", {7'd0, resp_valid}, 8'd0);
      check("rst:resp_id", {7'd0, resp_id}, 8'd0);
      check("rst:busy", {7'd0, busy}, 8'd0);
      check("rst:req_ready", {6'd0, req_ready}, 8'd0);
      do_reset();

      // Requester 0 alone: 3 + 4.
      req_a0 = 4'd3; req_b0 = 4'd4; req_op0 = 2'd0;
      run_op("add", 2'b01, 0);

      // Both valid from reset: r0 then r1 then r0 again.
      do_reset();
      req_a0 = 4'd15; req_b0 = 4'd15; req_op0 = 2'd1;
      req_a1 = 4'd2;  req_b1 = 4'd5;  req_op1 = 2'd2;
      run_op("rr1", 2'b11, 0);
      run_op("rr2", 2'b11, 0);
      run_op("rr3", 2'b11, 0);

      // Single requester granted back-to-back.
      req_a1 = 4'd0; req_b1 = 4'd15; req_op1 = 2'd2;
      run_op("b2b1", 2'b10, 0);
      req_a1 = 4'd15; req_b1 = 4'd15; req_op1 = 2'd0;
      run_op("b2b2", 2'b10, 0);

      // Response back-pressure for 5 cycles.
      req_a0 = 4'hC; req_b0 = 4'hA; req_op0 = 2'd3;
      run_op("stall", 2'b01, 5);

      // Reset during WAIT discards the operation and restores the pointer.
      req_a0 = 4'd9; req_b0 = 4'd9; req_op0 = 2'd1;
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst:resp_valid", {7'd0, resp_valid}, 8'd0);
      check("midrst:busy", {7'd0, busy}, 8'd0);
      sb_id.delete(); sb_data.delete();
      exp_last = 1'b1; exp_g0 = 0; exp_g1 = 0; exp_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      req_a0 = 4'd5; req_b0 = 4'd6; req_op0 = 2'd0;
      req_a1 = 4'd7; req_b1 = 4'd3; req_op1 = 2'd3;
      run_op("post_rst", 2'b11, 0);
      run_op("post_rst2", 2'b11, 4);

      // Fixed priority: r0 wins three times in a row with both held valid.
      req_a0 = 4'd6; req_b0 = 4'd7; req_op0 = 2'd1;
      req_valid_fp = 2'b11;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("fp:grant", {6'd0, req_ready_fp}, 8'd1);
         @(negedge clk);
         @(negedge clk);
         @(negedge clk);
         #1;
         check("fp:resp_valid", {7'd0, resp_valid_fp}, 8'd1);
         check("fp:resp_id", {7'd0, resp_id_fp}, 8'd0);
         check("fp:resp_data", resp_data_fp, model(4'd6, 4'd7, 2'd1));
         @(negedge clk);
      end
      req_valid_fp = 2'b00;

`ifdef ALU_RR_SCHED_STATS_EN
      check("stats:fp_g0", grant_cnt0_fp, 8'd3);
      check("stats:fp_g1", grant_cnt1_fp, 8'd0);
      check("stats:stall", stall_cnt, 8'(exp_stall));
      check("stats:g1", grant_cnt1, 8'(exp_g1));
      req_a0 = 4'd1; req_b0 = 4'd1; req_op0 = 2'd0;
      for (int k = 0; k < 300; k++) begin
         run_op("sat", 2'b01, 0);
      end
      check("stats:g0_sat", grant_cnt0, 8'(exp_g0));
      check("stats:g0_255", grant_cnt0, 8'd255);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
